// File: rtl/spm_seq_scratchpad_pkg.sv
// Shared bus widths, bank-group field layout and sequencer state encoding
// for the sequenced scratchpad.
package spm_seq_scratchpad_pkg;

  localparam int A_W        = 8;
  localparam int D_W        = 32;
  localparam int EX_BUS_W   = 2 + A_W + D_W;
  localparam int L_C_BUS_W  = 2 + A_W + D_W;
  localparam int C_L_BUS_W  = 1 + D_W;

  localparam int BG_FIELD_W = 6;
  localparam int MODE_OFS   = 0;
  localparam int SEL_OFS    = 1;
  localparam int EN_OFS     = 2;
  localparam int FSEL_OFS   = 3;
  localparam int FLUSH_OFS  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seqState_t;

  typedef struct packed {
    logic           wen;
    logic           ren;
    logic [A_W-1:0] addr;
    logic [D_W-1:0] data;
  } busOp_t;

  // The execution bus already has the same bit order as busOp_t.
  function automatic busOp_t decodeEx(input logic [EX_BUS_W-1:0] bus);
    return busOp_t'(bus);
  endfunction

  function automatic busOp_t decodeSw(input logic [L_C_BUS_W-1:0] bus);
    busOp_t op;
    op.wen  = bus[L_C_BUS_W-1];
    op.data = bus[A_W+1 +: D_W];
    op.ren  = bus[A_W];
    op.addr = bus[A_W-1:0];
    return op;
  endfunction

endpackage

// File: rtl/spm_seq_scratchpad_if.sv
// Config-write handshake and run-control signals of the sequenced scratchpad.
interface spm_seq_scratchpad_if #(
  parameter int NUM_BG    = 4,
  parameter int CFG_DEPTH = 16,
  parameter int DWELL_W   = 8
);
  import spm_seq_scratchpad_pkg::*;

  localparam int CW = DWELL_W + BG_FIELD_W * NUM_BG;
  localparam int IW = $clog2(CFG_DEPTH);

  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_data;
  logic          cfg_clear;
  logic          start;
  logic          stop;
  logic [7:0]    loop_cnt;
  logic          busy;
  logic          done;
  logic [IW-1:0] cur_idx;

  modport master (
    output cfg_valid, cfg_data, cfg_clear, start, stop, loop_cnt,
    input  cfg_ready, busy, done, cur_idx
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_clear, start, stop, loop_cnt,
    output cfg_ready, busy, done, cur_idx
  );

endinterface

// File: rtl/bankgroup.sv
// One scratchpad bank group: four 256-word banks picked by fifo_sel, registered
// read port, overwrite or accumulate writes, and a flush that clears read data.
module bankgroup
  import spm_seq_scratchpad_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           i_en,
  input  logic           i_mode,
  input  logic [1:0]     i_fifo_sel,
  input  logic           i_flush,
  input  logic           i_wen,
  input  logic           i_ren,
  input  logic [A_W-1:0] i_addr,
  input  logic [D_W-1:0] i_data,
  output logic           o_rvalid,
  output logic [D_W-1:0] o_rdata
);

  logic [D_W-1:0] r_mem [0:(4 << A_W)-1];
  logic [A_W+1:0] w_idx;
  logic           r_rvalid;
  logic [D_W-1:0] r_rdata;

  assign w_idx    = {i_fifo_sel, i_addr};
  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;

  // Mode 1 accumulates into the addressed word instead of overwriting it.
  always_ff @(posedge clk) begin
    if (i_en && i_wen) begin
      r_mem[w_idx] <= i_mode ? (r_mem[w_idx] + i_data) : i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= i_en && i_ren;
      if (i_en && i_ren) begin
        r_rdata <= r_mem[w_idx];
      end
    end
  end

endmodule

// File: rtl/spm_cfg_seq.sv
// Config buffer and IDLE/RUN/DONE sequencer that steps bank-group instructions.
// Define SPM_LOOP_EN to repeat the program loop_cnt extra times.
module spm_cfg_seq
  import spm_seq_scratchpad_pkg::*;
#(
  parameter  int NUM_BG    = 4,
  parameter  int CFG_DEPTH = 16,
  parameter  int DWELL_W   = 8,
  localparam int FW        = BG_FIELD_W * NUM_BG,
  localparam int CW        = DWELL_W + FW,
  localparam int IW        = $clog2(CFG_DEPTH)
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cfg_valid,
  output logic          o_cfg_ready,
  input  logic [CW-1:0] i_cfg_data,
  input  logic          i_cfg_clear,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic [7:0]    i_loop_cnt,
  output logic          o_busy,
  output logic          o_done,
  output logic [IW-1:0] o_cur_idx,
  output logic [FW-1:0] o_inst
);

  seqState_t          r_state, w_stateNxt;
  logic [IW:0]        r_wrCnt, w_wrCntNxt;
  logic [IW-1:0]      r_rdPtr, w_rdPtrNxt;
  logic [FW-1:0]      r_inst, w_instNxt;
  logic [DWELL_W-1:0] r_dwellCnt, w_dwellNxt;
  logic [CW-1:0]      r_buf [CFG_DEPTH];
  logic               w_cfgFire;
  logic               w_lastEntry;
  logic               w_load;
`ifdef SPM_LOOP_EN
  logic [7:0]         r_loopsLeft, w_loopsNxt;
`else
  logic               w_unusedLoopCnt;
  assign w_unusedLoopCnt = ^i_loop_cnt;
`endif

  // Ready depends only on state and fill level, never on the active instruction.
  assign o_cfg_ready = (r_state == ST_IDLE) && (r_wrCnt < (IW+1)'(CFG_DEPTH));
  assign w_cfgFire   = i_cfg_valid && o_cfg_ready;
  assign w_lastEntry = ({1'b0, r_rdPtr} == (r_wrCnt - 1'b1));
  assign o_busy      = (r_state == ST_RUN);
  assign o_done      = (r_state == ST_DONE);
  assign o_cur_idx   = r_rdPtr;
  assign o_inst      = r_inst;

  always_comb begin
    w_stateNxt = r_state;
    w_wrCntNxt = r_wrCnt;
    w_rdPtrNxt = r_rdPtr;
    w_instNxt  = r_inst;
    w_dwellNxt = r_dwellCnt;
    w_load     = 1'b0;
`ifdef SPM_LOOP_EN
    w_loopsNxt = r_loopsLeft;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (i_cfg_clear) begin
          w_wrCntNxt = '0;
        end else begin
          if (w_cfgFire) w_wrCntNxt = r_wrCnt + 1'b1;
          if (i_start && (r_wrCnt != '0)) begin
            w_stateNxt = ST_RUN;
            w_rdPtrNxt = '0;
            w_load     = 1'b1;
`ifdef SPM_LOOP_EN
            w_loopsNxt = i_loop_cnt;
`endif
          end
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          w_stateNxt = ST_IDLE;
          w_instNxt  = '0;
        end else if (r_dwellCnt != '0) begin
          w_dwellNxt = r_dwellCnt - 1'b1;
        end else if (!w_lastEntry) begin
          w_rdPtrNxt = r_rdPtr + 1'b1;
          w_load     = 1'b1;
`ifdef SPM_LOOP_EN
        end else if (r_loopsLeft != '0) begin
          w_rdPtrNxt = '0;
          w_loopsNxt = r_loopsLeft - 1'b1;
          w_load     = 1'b1;
`endif
        end else begin
          w_stateNxt = ST_DONE;
          w_instNxt  = '0;
        end
      end
      ST_DONE: w_stateNxt = ST_IDLE;
      default: w_stateNxt = ST_IDLE;
    endcase
    if (w_load) begin
      w_instNxt  = r_buf[w_rdPtrNxt][FW-1:0];
      w_dwellNxt = r_buf[w_rdPtrNxt][CW-1 -: DWELL_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wrCnt     <= '0;
      r_rdPtr     <= '0;
      r_inst      <= '0;
      r_dwellCnt  <= '0;
`ifdef SPM_LOOP_EN
      r_loopsLeft <= '0;
`endif
    end else begin
      r_state     <= w_stateNxt;
      r_wrCnt     <= w_wrCntNxt;
      r_rdPtr     <= w_rdPtrNxt;
      r_inst      <= w_instNxt;
      r_dwellCnt  <= w_dwellNxt;
`ifdef SPM_LOOP_EN
      r_loopsLeft <= w_loopsNxt;
`endif
    end
  end

  // Buffer storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && !i_cfg_clear && w_cfgFire) begin
      r_buf[r_wrCnt[IW-1:0]] <= i_cfg_data;
    end
  end

endmodule

// File: rtl/spm_seq_scratchpad.sv
// Sequenced scratchpad top: config sequencer driving NUM_BG bank groups, each
// fed from the execution bus or its own switch slice.
module spm_seq_scratchpad
  import spm_seq_scratchpad_pkg::*;
#(
  parameter int NUM_BG    = 4,
  parameter int CFG_DEPTH = 16,
  parameter int DWELL_W   = 8
)(
  input  logic                         clk,
  input  logic                         rst,
  spm_seq_scratchpad_if.slave          ctrl,
  input  logic [EX_BUS_W-1:0]          ex_bus,
  input  logic [NUM_BG*L_C_BUS_W-1:0]  switch_in,
  output logic [NUM_BG*C_L_BUS_W-1:0]  switch_out
);

  logic [NUM_BG*BG_FIELD_W-1:0] w_inst;
  busOp_t                       w_exOp;

  assign w_exOp = decodeEx(ex_bus);

  spm_cfg_seq #(
    .NUM_BG    (NUM_BG),
    .CFG_DEPTH (CFG_DEPTH),
    .DWELL_W   (DWELL_W)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .i_cfg_valid (ctrl.cfg_valid),
    .o_cfg_ready (ctrl.cfg_ready),
    .i_cfg_data  (ctrl.cfg_data),
    .i_cfg_clear (ctrl.cfg_clear),
    .i_start     (ctrl.start),
    .i_stop      (ctrl.stop),
    .i_loop_cnt  (ctrl.loop_cnt),
    .o_busy      (ctrl.busy),
    .o_done      (ctrl.done),
    .o_cur_idx   (ctrl.cur_idx),
    .o_inst      (w_inst)
  );

  for (genvar g = 0; g < NUM_BG; g++) begin : g_bg
    logic [BG_FIELD_W-1:0] w_field;
    busOp_t                w_swOp;
    busOp_t                w_op;

    assign w_field = w_inst[g*BG_FIELD_W +: BG_FIELD_W];
    assign w_swOp  = decodeSw(switch_in[g*L_C_BUS_W +: L_C_BUS_W]);
    assign w_op    = w_field[SEL_OFS] ? w_swOp : w_exOp;

    bankgroup u_bg (
      .clk        (clk),
      .rst        (rst),
      .i_en       (w_field[EN_OFS]),
      .i_mode     (w_field[MODE_OFS]),
      .i_fifo_sel (w_field[FSEL_OFS +: 2]),
      .i_flush    (w_field[FLUSH_OFS]),
      .i_wen      (w_op.wen),
      .i_ren      (w_op.ren),
      .i_addr     (w_op.addr),
      .i_data     (w_op.data),
      .o_rvalid   (switch_out[g*C_L_BUS_W + D_W]),
      .o_rdata    (switch_out[g*C_L_BUS_W +: D_W])
    );
  end

endmodule

// File: tb/tb_spm_seq_scratchpad.sv
// Self-checking bench for spm_seq_scratchpad: program sequencing, buffer
// overflow, stop, bus routing and reset, against a behavioural model.
module tb_spm_seq_scratchpad;
  import spm_seq_scratchpad_pkg::*;

  localparam int NUM_BG    = 4;
  localparam int CFG_DEPTH = 16;
  localparam int DWELL_W   = 8;
  localparam int CW        = DWELL_W + BG_FIELD_W * NUM_BG;
  localparam int IW        = $clog2(CFG_DEPTH);
  localparam logic [5:0] BG_EN    = 6'b000100;
  localparam logic [5:0] BG_EN_SW = 6'b000110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [EX_BUS_W-1:0]         ex_bus = '0;
  logic [NUM_BG*L_C_BUS_W-1:0] switch_in = '0;
  logic [NUM_BG*C_L_BUS_W-1:0] switch_out;

  int errors = 0;
  int checks = 0;
  int progLen;
  int dw [CFG_DEPTH];
  logic [CW-1:0] progMem [CFG_DEPTH];

  spm_seq_scratchpad_if #(.NUM_BG(NUM_BG), .CFG_DEPTH(CFG_DEPTH), .DWELL_W(DWELL_W)) ctrl ();

  spm_seq_scratchpad #(.NUM_BG(NUM_BG), .CFG_DEPTH(CFG_DEPTH), .DWELL_W(DWELL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl       (ctrl),
    .ex_bus     (ex_bus),
    .switch_in  (switch_in),
    .switch_out (switch_out)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] mkEntry(input logic [DWELL_W-1:0] dwell,
                                            input logic [5:0] f0, input logic [5:0] f1,
                                            input logic [5:0] f2, input logic [5:0] f3);
    return {dwell, f3, f2, f1, f0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeProgram();
    ctrl.cfg_clear = 1'b1;
    tick();
    ctrl.cfg_clear = 1'b0;
    for (int i = 0; i < progLen; i++) begin
      ctrl.cfg_valid = 1'b1;
      ctrl.cfg_data  = progMem[i];
      tick();
    end
    ctrl.cfg_valid = 1'b0;
  endtask

  task automatic startRun(input int loops);
    ctrl.loop_cnt = 8'(loops);
    ctrl.start    = 1'b1;
    tick();
    ctrl.start    = 1'b0;
  endtask

  task automatic test_reset();
    ctrl.cfg_valid = 1'b0; ctrl.cfg_data = '0; ctrl.cfg_clear = 1'b0;
    ctrl.start = 1'b0; ctrl.stop = 1'b0; ctrl.loop_cnt = '0;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (ctrl.busy !== 1'b0 || ctrl.done !== 1'b0 || ctrl.cur_idx !== '0 || ctrl.cfg_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_state: busy=%b done=%b cur_idx=%0d ready=%b, expected 0 0 0 1",
               ctrl.busy, ctrl.done, ctrl.cur_idx, ctrl.cfg_ready);
    end
    checks++;
    if (switch_out !== '0) begin
      errors++;
      $display("[TB] FAIL reset_switch_out: got %h, expected 0", switch_out);
    end
    rst = 1'b0;
    tick();
  endtask

  // Case 0: dwell {0,2,1}; case 1: two zero-dwell entries with loop_cnt=2; rest random.
  task automatic test_sequences();
    int expIdx[$];
    int loops;
    int passes;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) begin
        progLen = 3; dw[0] = 0; dw[1] = 2; dw[2] = 1; loops = 0;
      end else if (c == 1) begin
        progLen = 2; dw[0] = 0; dw[1] = 0; loops = 2;
      end else begin
        progLen = $urandom_range(1, 5);
        loops   = $urandom_range(0, 3);
        for (int i = 0; i < progLen; i++) dw[i] = $urandom_range(0, 3);
      end
      for (int i = 0; i < progLen; i++) progMem[i] = mkEntry(DWELL_W'(dw[i]), BG_EN, 6'd0, 6'd0, 6'd0);
`ifdef SPM_LOOP_EN
      passes = loops + 1;
`else
      passes = 1;
`endif
      expIdx.delete();
      for (int p = 0; p < passes; p++)
        for (int i = 0; i < progLen; i++)
          for (int r = 0; r <= dw[i]; r++) expIdx.push_back(i);
      writeProgram();
      startRun(loops);
      for (int k = 0; k < expIdx.size(); k++) begin
        if (k > 0) tick();
        checks++;
        if (ctrl.busy !== 1'b1 || ctrl.cur_idx !== IW'(expIdx[k])) begin
          errors++;
          $display("[TB] FAIL seq case%0d step%0d: busy=%b cur_idx=%0d, expected busy=1 cur_idx=%0d",
                   c, k, ctrl.busy, ctrl.cur_idx, expIdx[k]);
        end
      end
      tick();
      checks++;
      if (ctrl.done !== 1'b1 || ctrl.busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL seq_done case%0d: done=%b busy=%b, expected done=1 busy=0", c, ctrl.done, ctrl.busy);
      end
      tick();
      checks++;
      if (ctrl.done !== 1'b0 || ctrl.busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL seq_done_width case%0d: done=%b busy=%b, expected 0 0", c, ctrl.done, ctrl.busy);
      end
    end
  endtask

  task automatic test_full();
    int expIdx[$];
    ctrl.cfg_clear = 1'b1;
    tick();
    ctrl.cfg_clear = 1'b0;
    for (int i = 0; i < CFG_DEPTH; i++) begin
      dw[i] = i % 2;
      checks++;
      if (ctrl.cfg_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL fill_ready entry%0d: ready=%b, expected 1", i, ctrl.cfg_ready);
      end
      ctrl.cfg_valid = 1'b1;
      ctrl.cfg_data  = mkEntry(DWELL_W'(dw[i]), BG_EN, 6'd0, 6'd0, 6'd0);
      tick();
    end
    checks++;
    if (ctrl.cfg_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_ready: ready=%b, expected 0", ctrl.cfg_ready);
    end
    ctrl.cfg_data = mkEntry(8'd5, 6'd0, 6'd0, 6'd0, 6'd0);
    tick();
    ctrl.cfg_valid = 1'b0;
    checks++;
    if (ctrl.cfg_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_ready: ready=%b, expected 0", ctrl.cfg_ready);
    end
    for (int i = 0; i < CFG_DEPTH; i++)
      for (int r = 0; r <= dw[i]; r++) expIdx.push_back(i);
    startRun(0);
    for (int k = 0; k < expIdx.size(); k++) begin
      if (k > 0) tick();
      checks++;
      if (ctrl.busy !== 1'b1 || ctrl.cur_idx !== IW'(expIdx[k])) begin
        errors++;
        $display("[TB] FAIL full_seq step%0d: busy=%b cur_idx=%0d, expected busy=1 cur_idx=%0d",
                 k, ctrl.busy, ctrl.cur_idx, expIdx[k]);
      end
    end
    tick();
    checks++;
    if (ctrl.done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_done: done=%b, expected 1", ctrl.done);
    end
    tick();
  endtask

  task automatic test_stop();
    bit sawDone;
    progLen = 2;
    progMem[0] = mkEntry(8'd3, 6'd0, BG_EN, 6'd0, 6'd0);
    progMem[1] = mkEntry(8'd3, 6'd0, BG_EN, 6'd0, 6'd0);
    writeProgram();
    startRun(0);
    ex_bus = {1'b0, 1'b1, 8'd3, 32'd0};
    tick();
    ex_bus = '0;
    checks++;
    if (switch_out[C_L_BUS_W + D_W] !== 1'b1 || ctrl.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stop_prerun: bg1 rvalid=%b busy=%b, expected 1 1", switch_out[C_L_BUS_W + D_W], ctrl.busy);
    end
    tick();
    ctrl.stop = 1'b1;
    tick();
    ctrl.stop = 1'b0;
    checks++;
    if (ctrl.busy !== 1'b0 || ctrl.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stop_idle: busy=%b done=%b, expected 0 0", ctrl.busy, ctrl.done);
    end
    ex_bus = {1'b0, 1'b1, 8'd3, 32'd0};
    tick();
    ex_bus = '0;
    checks++;
    if (switch_out[C_L_BUS_W + D_W] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stop_inst_cleared: bg1 rvalid=%b, expected 0", switch_out[C_L_BUS_W + D_W]);
    end
    sawDone = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ctrl.done !== 1'b0 || ctrl.busy !== 1'b0) sawDone = 1'b1;
      tick();
    end
    checks++;
    if (sawDone) begin
      errors++;
      $display("[TB] FAIL stop_no_done: saw done/busy after stop=1, expected 0");
    end
  endtask

  task automatic test_switch();
    logic [31:0] m0 [256];
    logic [31:0] m2 [256];
    bit          v0 [256];
    bit          v2 [256];
    for (int i = 0; i < 256; i++) begin v0[i] = 1'b0; v2[i] = 1'b0; end
    progLen = 1;
    progMem[0] = mkEntry(8'd255, BG_EN, 6'd0, BG_EN_SW, 6'd0);
    writeProgram();
    startRun(0);
    switch_in[2*L_C_BUS_W +: L_C_BUS_W] = {1'b1, 32'hDEADBEEF, 1'b0, 8'h05};
    ex_bus = {1'b1, 1'b0, 8'h05, 32'h12345678};
    m2[5] = 32'hDEADBEEF; v2[5] = 1'b1;
    m0[5] = 32'h12345678; v0[5] = 1'b1;
    tick();
    switch_in[2*L_C_BUS_W +: L_C_BUS_W] = {1'b0, 32'd0, 1'b1, 8'h05};
    ex_bus = {1'b0, 1'b1, 8'h05, 32'd0};
    tick();
    checks++;
    if (switch_out[2*C_L_BUS_W + D_W] !== 1'b1 || switch_out[2*C_L_BUS_W +: D_W] !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL bg2_switch_read: rvalid=%b data=%h, expected 1 deadbeef",
               switch_out[2*C_L_BUS_W + D_W], switch_out[2*C_L_BUS_W +: D_W]);
    end
    checks++;
    if (switch_out[D_W] !== 1'b1 || switch_out[0 +: D_W] !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL bg0_ex_read: rvalid=%b data=%h, expected 1 12345678", switch_out[D_W], switch_out[0 +: D_W]);
    end
    for (int c = 0; c < 40; c++) begin
      logic        exW, exR, swW, swR, k0, k2;
      logic [7:0]  exA, swA;
      logic [31:0] exD, swD, e0, e2;
      exW = 1'($urandom); exR = 1'($urandom); exA = 8'($urandom_range(0, 7)); exD = $urandom;
      swW = 1'($urandom); swR = 1'($urandom); swA = 8'($urandom_range(0, 7)); swD = $urandom;
      k0 = exR && v0[exA]; e0 = m0[exA];
      k2 = swR && v2[swA]; e2 = m2[swA];
      if (exW) begin m0[exA] = exD; v0[exA] = 1'b1; end
      if (swW) begin m2[swA] = swD; v2[swA] = 1'b1; end
      ex_bus = {exW, exR, exA, exD};
      switch_in = '0;
      switch_in[2*L_C_BUS_W +: L_C_BUS_W] = {swW, swD, swR, swA};
      tick();
      checks++;
      if (switch_out[D_W] !== exR || (k0 && switch_out[0 +: D_W] !== e0)) begin
        errors++;
        $display("[TB] FAIL bg0_rand cyc%0d: rvalid=%b data=%h, expected rvalid=%b data=%h",
                 c, switch_out[D_W], switch_out[0 +: D_W], exR, e0);
      end
      checks++;
      if (switch_out[2*C_L_BUS_W + D_W] !== swR || (k2 && switch_out[2*C_L_BUS_W +: D_W] !== e2)) begin
        errors++;
        $display("[TB] FAIL bg2_rand cyc%0d: rvalid=%b data=%h, expected rvalid=%b data=%h",
                 c, switch_out[2*C_L_BUS_W + D_W], switch_out[2*C_L_BUS_W +: D_W], swR, e2);
      end
      checks++;
      if (switch_out[C_L_BUS_W + D_W] !== 1'b0 || switch_out[3*C_L_BUS_W + D_W] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL disabled_bg cyc%0d: bg1 rvalid=%b bg3 rvalid=%b, expected 0 0",
                 c, switch_out[C_L_BUS_W + D_W], switch_out[3*C_L_BUS_W + D_W]);
      end
    end
    ex_bus = '0;
    switch_in = '0;
    ctrl.stop = 1'b1;
    tick();
    ctrl.stop = 1'b0;
    tick();
  endtask

  task automatic test_rst_midrun();
    bit bad;
    progLen = 1;
    progMem[0] = mkEntry(8'd50, BG_EN, 6'd0, 6'd0, 6'd0);
    writeProgram();
    startRun(0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ctrl.busy !== 1'b0 || ctrl.done !== 1'b0 || ctrl.cur_idx !== '0 || ctrl.cfg_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_midrun: busy=%b done=%b cur_idx=%0d ready=%b, expected 0 0 0 1",
               ctrl.busy, ctrl.done, ctrl.cur_idx, ctrl.cfg_ready);
    end
    ex_bus = {1'b0, 1'b1, 8'd0, 32'd0};
    tick();
    ex_bus = '0;
    checks++;
    if (switch_out[D_W] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_bg_disabled: bg0 rvalid=%b, expected 0", switch_out[D_W]);
    end
    ctrl.start = 1'b1;
    tick();
    ctrl.start = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ctrl.busy !== 1'b0 || ctrl.done !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL start_empty: busy/done seen=1, expected 0");
    end
  endtask

  initial begin
    test_reset();
    test_sequences();
    test_full();
    test_stop();
    test_switch();
    test_rst_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spm_seq_scratchpad.md
SPM_SEQ_SCRATCHPAD -- requirements
Module: spm_seq_scratchpad

Interface
REQ-001 SHALL have parameter NUM_BG, default 4: number of bank groups, allowed range 1..8.
REQ-002 SHALL have parameter CFG_DEPTH, default 16: number of config-buffer entries, a power of 2 from 2 to 256.
REQ-003 SHALL have parameter DWELL_W, default 8: width of the per-entry dwell field.
REQ-004 SHALL have ports clk (in, 1, clock) and rst (in, 1, synchronous active-high reset); one clock, with synchronous active-high reset.
REQ-005 SHALL have cfg_valid (in, 1), cfg_ready (out, 1) and cfg_data (in, DWELL_W+6*NUM_BG) as the config-write handshake.
REQ-006 SHALL have cfg_clear (in, 1): empties the config buffer while IDLE.
REQ-007 SHALL have start (in, 1), stop (in, 1) and loop_cnt (in, 8): the number of extra passes through the program.
REQ-008 SHALL have busy (out, 1), done (out, 1, one-cycle pulse) and cur_idx (out, clog2(CFG_DEPTH)).
REQ-009 SHALL have ex_bus (in, `EX_bus), switch_in (in, NUM_BG*`L_C_bus) and switch_out (out, NUM_BG*`C_L_bus).

Function
REQ-010 SHALL decode ex_bus as {wen, ren, addr[`A_W], data[32]}, MSB first.
REQ-011 SHALL decode switch_in slice g as {wen, data[32], ren, addr[`A_W]}.
REQ-012 SHALL lay out cfg_data as {dwell[DWELL_W], BG(NUM_BG-1) field … BG0 field}.
REQ-013 SHALL define each BG field as 6 bits: {flush, fifo_sel[1:0], en, sel, mode}.
REQ-014 SHALL drive each BG g's data, addr, wen and ren from switch_in slice g when sel=1, else from ex_bus.
REQ-015 SHALL take en, mode, fifo_sel and flush for BG g from the active instruction register inst_r.
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 SHALL assert cfg_ready when state==IDLE && wr_cnt<CFG_DEPTH.
REQ-018 SHALL, on cfg_valid&&cfg_ready, write buf[wr_cnt] and increment wr_cnt.
REQ-019 SHALL ignore cfg_valid when not ready, leaving data and count unchanged.
REQ-020 SHALL, on cfg_clear in IDLE, set wr_cnt=0.
REQ-021 SHALL give cfg_clear priority over a same-cycle write, and ignore cfg_clear outside IDLE.
REQ-022 SHALL, on start in IDLE with wr_cnt>0, go to RUN with rd_ptr=0, inst_r=buf[0], dwell_cnt=buf[0].dwell and loops_left=loop_cnt.
REQ-023 SHALL make inst_r visible to the bank groups one cycle after start.
REQ-024 SHALL ignore start when wr_cnt==0 or when not IDLE.
REQ-025 SHALL, in RUN, decrement dwell_cnt while it is nonzero, so each entry is active for dwell+1 cycles.
REQ-026 SHALL, in RUN with dwell_cnt==0 and rd_ptr<wr_cnt-1, load the next entry (rd_ptr+1) into inst_r and dwell_cnt.
REQ-027 SHALL, in RUN with dwell_cnt==0 and rd_ptr==wr_cnt-1, wrap to rd_ptr=0 and decrement loops_left when loops_left!=0; otherwise go to DONE with inst_r=0.
REQ-028 SHALL hold DONE for exactly one cycle with done=1, then go to IDLE.
REQ-029 SHALL, on stop in RUN, go to IDLE next cycle with inst_r=0 and no done pulse; stop has priority over an entry advance.
REQ-030 SHALL set busy=1 in RUN and 0 otherwise, and drive cur_idx=rd_ptr.
REQ-031 SHALL have no combinational path from inst_r to cfg_ready.

Reset
REQ-032 SHALL, on rst, set state=IDLE, wr_cnt=0, rd_ptr=0, inst_r=0, dwell_cnt=0, loops_left=0, done=0 and busy=0.
REQ-033 SHALL leave buffer contents unreset.
REQ-034 SHALL let rst during RUN abort immediately, with all BG en=0 the cycle after.

Configuration
REQ-035 SHALL, with SPM_LOOP_EN defined, implement loop_cnt repetition as in REQ-027.
REQ-036 SHALL, with SPM_LOOP_EN undefined, ignore loop_cnt, omit loops_left, and make the last entry always go to DONE.

Structure
REQ-037 SHALL place BG field offsets, the FSM state encoding and the BG_FIELD_W=6 constant in a shared package/include alongside param_define.v.
REQ-038 SHALL instantiate the existing bankgroup module NUM_BG times in a generate loop.
REQ-039 SHALL implement the sequencer FSM and config buffer as one sub-module, spm_cfg_seq.

Verification
REQ-040 SHALL cover: write 3 entries with dwell {0,2,1} and BG0 en=1, then start, loop_cnt=0 -> cur_idx sequence 0,1,1,1,2,2, then done pulse 1 cycle, busy low.
REQ-041 SHALL cover: write CFG_DEPTH=16 entries, then a 17th cfg_valid -> cfg_ready=0, wr_cnt stays 16, buffer unchanged.
REQ-042 SHALL cover: with SPM_LOOP_EN, 2 entries dwell 0, loop_cnt=2 -> cur_idx 0,1,0,1,0,1 then done; without the macro -> 0,1 then done.
REQ-043 SHALL cover: stop asserted at the 3rd RUN cycle -> IDLE next cycle, inst_r=0, done never asserted.
REQ-044 SHALL cover: BG2 sel=1, switch_in slice 2 wen=1, addr=0x05, data=0xDEADBEEF -> subsequent read of BG2 addr 0x05 returns 0xDEADBEEF; BG0 sel=0 follows ex_bus.
REQ-045 SHALL cover: rst mid-RUN and start with wr_cnt==0 -> state IDLE, busy=0, no done pulse.
